// File: rtl/mips_pkg.sv
// Shared MIPS definitions: sequencer state encoding, memory address select, opcode/funct values.
package mips_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic MEM_ADDR_PC  = 1'b0;
  localparam logic MEM_ADDR_ALU = 1'b1;

  // Primary opcodes
  localparam logic [OPCODE_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_J       = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_LB      = 6'h20;
  localparam logic [OPCODE_W-1:0] OP_LH      = 6'h21;
  localparam logic [OPCODE_W-1:0] OP_LWL     = 6'h22;
  localparam logic [OPCODE_W-1:0] OP_LW      = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_LBU     = 6'h24;
  localparam logic [OPCODE_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_LWR     = 6'h26;
  localparam logic [OPCODE_W-1:0] OP_SB      = 6'h28;
  localparam logic [OPCODE_W-1:0] OP_SH      = 6'h29;
  localparam logic [OPCODE_W-1:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [FUNCT_W-1:0] FN_JR    = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_JALR  = 6'h09;
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;

endpackage

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS sequencer: walks fetch/decode/execute/memory/writeback, stalls on
// memory waitrequest, times mul/div occupancy, detects halt and counts active cycles.
module mips_multicycle_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_waitrequest,
  input  logic        pc_is_zero,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_muldiv,
  input  logic        writes_reg,
  output logic        active,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        hilo_write,
  output logic [2:0]  state,
  output logic [31:0] cycle_count
);
  import mips_pkg::*;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CYC_W  = 32;
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   muldiv_cnt_q, muldiv_cnt_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;
  logic               active_c;

  // State, mul/div counter and cycle counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      muldiv_cnt_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      muldiv_cnt_q  <= muldiv_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Running indication and free-running active-cycle counter (wraps naturally)
  always_comb begin
    active_c      = !reset && (state_q != S_HALTED);
    cycle_count_d = active_c ? cycle_count_q + CYC_W'(1) : cycle_count_q;
  end

  // Next-state and per-state strobe decode; everything forced quiet while reset is high
  always_comb begin
    state_d      = state_q;
    muldiv_cnt_d = muldiv_cnt_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = MEM_ADDR_PC;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    hilo_write   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (pc_is_zero) begin
          state_d = S_HALTED;
        end else begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_write = 1'b1;
        if (is_muldiv) begin
          state_d      = S_MULDIV;
          muldiv_cnt_d = MULDIV_LOAD;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_addr_sel = MEM_ADDR_ALU;
        mem_read     = is_load;
        // Load wins if both flags ever appear, keeping read and write exclusive
        mem_write    = is_store && !is_load;
        if (!mem_waitrequest) begin
          state_d = is_load ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write = writes_reg;
        state_d   = S_FETCH;
      end
      S_MULDIV: begin
        if (muldiv_cnt_q == '0) begin
          hilo_write = 1'b1;
          state_d    = S_FETCH;
        end else begin
          muldiv_cnt_d = muldiv_cnt_q - CNT_W'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = MEM_ADDR_PC;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      hilo_write   = 1'b0;
    end
  end

  assign active      = active_c;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed bench for the multi-cycle sequencer: table of per-cycle vectors plus
// hand-written mul/div, halt and reset-mid-access sequences.
module tb_mips_multicycle_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, mem_waitrequest, pc_is_zero;
  logic        is_load, is_store, is_muldiv, writes_reg;
  logic        active, mem_read, mem_write, mem_addr_sel;
  logic        ir_write, pc_write, reg_write, hilo_write;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic [7:0]  strb;

  int passed = 0;
  int total  = 0;

  mips_multicycle_sequencer #(.MULDIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .mem_waitrequest(mem_waitrequest),
    .pc_is_zero(pc_is_zero), .is_load(is_load), .is_store(is_store),
    .is_muldiv(is_muldiv), .writes_reg(writes_reg), .active(active),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .hilo_write(hilo_write), .state(state), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // {active, mem_read, mem_write, mem_addr_sel, ir_write, pc_write, reg_write, hilo_write}
  assign strb = {active, mem_read, mem_write, mem_addr_sel,
                 ir_write, pc_write, reg_write, hilo_write};

  typedef struct {
    string       name;
    logic [6:0]  in_v;   // {reset, waitreq, pc_is_zero, is_load, is_store, is_muldiv, writes_reg}
    logic [7:0]  strb;
    state_t      st;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [6:0] i, input logic [7:0] s,
                     input state_t st, input logic [31:0] c);
    vec_t v;
    v.name = n; v.in_v = i; v.strb = s; v.st = st; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic [6:0] i);
    {reset, mem_waitrequest, pc_is_zero, is_load, is_store, is_muldiv, writes_reg} = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hilo_pulses;

  initial begin
    // Reset, then ALU op
    add("rst",      7'b1000000, 8'b0000_0000, S_FETCH,  0);
    add("alu_f",    7'b0000001, 8'b1100_1000, S_FETCH,  0);
    add("alu_d",    7'b0000001, 8'b1000_0000, S_DECODE, 1);
    add("alu_e",    7'b0000001, 8'b1000_0100, S_EXEC,   2);
    add("alu_w",    7'b0000001, 8'b1000_0010, S_WB,     3);
    // LW with 3 fetch wait states and 2 memory wait states
    add("lw_fw0",   7'b0100001, 8'b1100_0000, S_FETCH,  4);
    add("lw_fw1",   7'b0100001, 8'b1100_0000, S_FETCH,  5);
    add("lw_fw2",   7'b0100001, 8'b1100_0000, S_FETCH,  6);
    add("lw_facc",  7'b0000001, 8'b1100_1000, S_FETCH,  7);
    add("lw_d",     7'b0001001, 8'b1000_0000, S_DECODE, 8);
    add("lw_e",     7'b0001001, 8'b1000_0100, S_EXEC,   9);
    add("lw_mw0",   7'b0101001, 8'b1101_0000, S_MEM,    10);
    add("lw_mw1",   7'b0101001, 8'b1101_0000, S_MEM,    11);
    add("lw_macc",  7'b0001001, 8'b1101_0000, S_MEM,    12);
    add("lw_w",     7'b0001001, 8'b1000_0010, S_WB,     13);
    // SW, zero wait
    add("sw_f",     7'b0000000, 8'b1100_1000, S_FETCH,  14);
    add("sw_d",     7'b0000100, 8'b1000_0000, S_DECODE, 15);
    add("sw_e",     7'b0000100, 8'b1000_0100, S_EXEC,   16);
    add("sw_m",     7'b0000100, 8'b1011_0000, S_MEM,    17);
    add("sw_back",  7'b0100000, 8'b1100_0000, S_FETCH,  18);

    drive(7'b1000000);
    tick();
    tick();

    foreach (vecs[k]) begin
      drive(vecs[k].in_v);
      #4;
      chk({vecs[k].name, "_strb"},  32'(strb),        32'(vecs[k].strb));
      chk({vecs[k].name, "_state"}, 32'(state),       32'(vecs[k].st));
      chk({vecs[k].name, "_count"}, cycle_count,      vecs[k].cnt);
      tick();
    end

    // MULT: 3 + 32 cycles, hilo_write single pulse on the 35th
    hilo_pulses = 0;
    drive(7'b0000010);
    for (int k = 1; k <= 35; k++) begin
      state_t exp_st;
      exp_st = (k == 1) ? S_FETCH : (k == 2) ? S_DECODE : (k == 3) ? S_EXEC : S_MULDIV;
      #4;
      if (hilo_write) hilo_pulses++;
      chk($sformatf("mul_hilo_c%0d", k), 32'(hilo_write), 32'(k == 35));
      chk($sformatf("mul_regw_c%0d", k), 32'(reg_write),  32'd0);
      chk($sformatf("mul_st_c%0d", k),   32'(state),      32'(exp_st));
      chk($sformatf("mul_cnt_c%0d", k),  cycle_count,     32'(18 + k));
      tick();
    end
    chk("mul_hilo_pulses", 32'(hilo_pulses), 32'd1);

    // Halt: pc_is_zero in FETCH, no memory request, absorbing
    drive(7'b0010000);
    #4;
    chk("halt_f_state", 32'(state), 32'(S_FETCH));
    chk("halt_f_count", cycle_count, 32'd54);
    chk("halt_f_strb",  32'(strb),   32'(8'b1000_0000));
    tick();
    for (int k = 0; k < 20; k++) begin
      drive({2'b00, k[0], 4'b0000});
      #4;
      chk($sformatf("halted_state_%0d", k), 32'(state),    32'(S_HALTED));
      chk($sformatf("halted_strb_%0d", k),  32'(strb),     32'd0);
      chk($sformatf("halted_count_%0d", k), cycle_count,   32'd55);
      tick();
    end

    // Reset out of HALTED, then SW stalled in MEM and reset mid-access
    drive(7'b1000000);
    #4;
    chk("hrst_strb", 32'(strb), 32'd0);
    tick();
    drive(7'b0000100);
    #4;
    chk("hrst_state", 32'(state), 32'(S_FETCH));
    chk("hrst_count", cycle_count, 32'd0);
    chk("rsw_f_strb", 32'(strb), 32'(8'b1100_1000));
    tick();
    tick();
    tick();
    drive(7'b0100100);
    #4;
    chk("rsw_m_state", 32'(state), 32'(S_MEM));
    chk("rsw_m_strb",  32'(strb),  32'(8'b1011_0000));
    tick();
    drive(7'b1100100);
    #4;
    chk("rsw_rst_strb", 32'(strb), 32'd0);
    tick();
    #4;
    chk("rsw_rst2_strb",  32'(strb),   32'd0);
    chk("rsw_rst2_state", 32'(state),  32'(S_FETCH));
    chk("rsw_rst2_count", cycle_count, 32'd0);
    drive(7'b0100100);
    #1;
    chk("rsw_rel_strb",  32'(strb),   32'(8'b1100_0000));
    chk("rsw_rel_state", 32'(state),  32'(S_FETCH));
    chk("rsw_rel_count", cycle_count, 32'd0);
    tick();
    #4;
    chk("rsw_rel_count1", cycle_count, 32'd1);
    chk("rsw_rel_state1", 32'(state),  32'(S_FETCH));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
